// File: rtl/alu_seq.sv
// Multi-cycle successor ALU: 1-cycle arith/logic/branch, WIDTH-iteration shift-add MUL (and DIV when ALU_DIV_EN is defined).
// Latency 1 edge for single-cycle ops, WIDTH+1 edges for MUL/DIV; in_ready drops while an iterative op runs, so in_valid must be held.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int OPW   = 5
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPW-1:0]       op,
    input  logic [WIDTH-1:0]     DatA,
    input  logic [WIDTH-1:0]     DatB,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   Rslt,
    output logic                 branch,
    output logic [3:0]           flags,
    output logic                 busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_AND = OPW'(2);
    localparam logic [OPW-1:0] OP_XOR = OPW'(3);
    localparam logic [OPW-1:0] OP_SHL = OPW'(4);
    localparam logic [OPW-1:0] OP_SHR = OPW'(5);
    localparam logic [OPW-1:0] OP_MOV = OPW'(6);
    localparam logic [OPW-1:0] OP_CMP = OPW'(7);
    localparam logic [OPW-1:0] OP_MUL = OPW'(8);
`ifdef ALU_DIV_EN
    localparam logic [OPW-1:0] OP_DIV = OPW'(9);
`endif
    localparam logic [OPW-1:0] OP_BEQ = OPW'(16);
    localparam logic [OPW-1:0] OP_BNE = OPW'(17);
    localparam logic [OPW-1:0] OP_BLT = OPW'(18);
    localparam logic [OPW-1:0] OP_BLE = OPW'(19);
    localparam logic [OPW-1:0] OP_BGT = OPW'(20);
    localparam logic [OPW-1:0] OP_BGE = OPW'(21);
    localparam logic [OPW-1:0] OP_B   = OPW'(22);
    localparam logic [OPW-1:0] OP_BOF = OPW'(23);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          iter;
    logic                   accept, last_iter;

    logic [WIDTH:0]         sum, diff;
    logic                   v_add, v_sub, shift_oor;
    logic [WIDTH-1:0]       shl_res, shr_res;

    logic [2*WIDTH-1:0]     sc_rslt;
    logic                   sc_branch, sc_flag_we, start_multi;
    logic [3:0]             sc_flags;

    logic [2*WIDTH-1:0]     mul_acc, mul_mcand, mul_acc_nxt;
    logic [WIDTH-1:0]       mul_mplier;

    assign in_ready  = (state == S_IDLE);
    assign busy      = ~in_ready;
    assign accept    = in_valid && in_ready;
    assign last_iter = (state == S_RUN) && (iter == CW'(WIDTH - 1));

    assign sum       = {1'b0, DatA} + {1'b0, DatB};
    assign diff      = {1'b0, DatA} - {1'b0, DatB};
    assign v_add     = (DatA[WIDTH-1] == DatB[WIDTH-1]) && (sum[WIDTH-1]  != DatA[WIDTH-1]);
    assign v_sub     = (DatA[WIDTH-1] != DatB[WIDTH-1]) && (diff[WIDTH-1] != DatA[WIDTH-1]);
    assign shift_oor = (32'(DatB) >= WIDTH);
    assign shl_res   = shift_oor ? '0 : (DatA << DatB);
    assign shr_res   = shift_oor ? '0 : (DatA >> DatB);

    assign mul_acc_nxt = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

`ifdef ALU_DIV_EN
    logic                   is_div;
    logic [WIDTH-1:0]       div_rem, div_quo, div_den;
    logic [WIDTH:0]         div_trial;
    logic                   div_ge;
    logic [WIDTH-1:0]       div_rem_nxt, div_quo_nxt;

    // Restoring step: shift the next dividend bit into the remainder, subtract if it fits.
    assign div_trial   = {div_rem, div_quo[WIDTH-1]};
    assign div_ge      = div_trial >= {1'b0, div_den};
    assign div_rem_nxt = div_ge ? (div_trial[WIDTH-1:0] - div_den) : div_trial[WIDTH-1:0];
    assign div_quo_nxt = {div_quo[WIDTH-2:0], div_ge};
`endif

    always_comb begin
        sc_rslt     = '0;
        sc_branch   = 1'b0;
        sc_flag_we  = 1'b0;
        sc_flags    = flags;
        start_multi = 1'b0;
        case (op)
            OP_ADD: begin
                sc_rslt    = (2*WIDTH)'(sum);
                sc_flag_we = 1'b1;
                sc_flags   = {sum[WIDTH-1], sum[WIDTH-1:0] == '0, sum[WIDTH], v_add};
            end
            OP_SUB, OP_CMP: begin
                sc_rslt    = (op == OP_SUB) ? (2*WIDTH)'(diff[WIDTH-1:0]) : '0;
                sc_flag_we = 1'b1;
                sc_flags   = {diff[WIDTH-1], diff[WIDTH-1:0] == '0, ~diff[WIDTH], v_sub};
            end
            OP_AND: sc_rslt = (2*WIDTH)'(DatA & DatB);
            OP_XOR: sc_rslt = (2*WIDTH)'(DatA ^ DatB);
            OP_SHL: sc_rslt = (2*WIDTH)'(shl_res);
            OP_SHR: sc_rslt = (2*WIDTH)'(shr_res);
            OP_MOV: sc_rslt = (2*WIDTH)'(DatB);
            OP_MUL: start_multi = 1'b1;
`ifdef ALU_DIV_EN
            OP_DIV: start_multi = 1'b1;
`endif
            // Branches read the registered flags, so a flag op one cycle earlier is already visible.
            OP_BEQ: sc_branch = flags[2];
            OP_BNE: sc_branch = ~flags[2];
            OP_BLT: sc_branch = ~flags[1];
            OP_BLE: sc_branch = ~flags[1] | flags[2];
            OP_BGT: sc_branch = flags[1] & ~flags[2];
            OP_BGE: sc_branch = flags[1];
            OP_B:   sc_branch = 1'b1;
            OP_BOF: sc_branch = flags[0];
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && start_multi) state_nxt = S_RUN;
            S_RUN:   if (last_iter) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            Rslt       <= '0;
            branch     <= 1'b0;
            flags      <= '0;
            iter       <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
`ifdef ALU_DIV_EN
            is_div     <= 1'b0;
            div_rem    <= '0;
            div_quo    <= '0;
            div_den    <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (accept && !start_multi) begin
                out_valid <= 1'b1;
                Rslt      <= sc_rslt;
                branch    <= sc_branch;
                if (sc_flag_we) flags <= sc_flags;
            end
            if (accept && start_multi) begin
                iter       <= '0;
                mul_acc    <= '0;
                mul_mcand  <= (2*WIDTH)'(DatA);
                mul_mplier <= DatB;
`ifdef ALU_DIV_EN
                is_div     <= (op == OP_DIV);
                div_rem    <= '0;
                div_quo    <= DatA;
                div_den    <= DatB;
`endif
            end
            if (state == S_RUN) begin
                iter       <= iter + 1'b1;
                mul_acc    <= mul_acc_nxt;
                mul_mcand  <= mul_mcand << 1;
                mul_mplier <= mul_mplier >> 1;
`ifdef ALU_DIV_EN
                div_rem    <= div_rem_nxt;
                div_quo    <= div_quo_nxt;
`endif
                if (last_iter) begin
                    out_valid <= 1'b1;
                    branch    <= 1'b0;
`ifdef ALU_DIV_EN
                    if (is_div) begin
                        Rslt     <= {div_rem_nxt, div_quo_nxt};
                        flags[0] <= (div_den == '0);
                    end else begin
                        Rslt     <= mul_acc_nxt;
                    end
`else
                    Rslt      <= mul_acc_nxt;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8); DIV vectors follow ALU_DIV_EN.
module tb_alu_seq;

    logic        Clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [7:0]  DatA, DatB;
    logic        out_valid;
    logic [15:0] Rslt;
    logic        branch;
    logic [3:0]  flags;
    logic        busy;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  SHL = 5'd4,  SHR = 5'd5;
    localparam logic [4:0] MOV = 5'd6,  CMP = 5'd7,  MUL = 5'd8,  DIV = 5'd9;
    localparam logic [4:0] BEQ = 5'd16, BNE = 5'd17, BLT = 5'd18, BLE = 5'd19;
    localparam logic [4:0] BGT = 5'd20, BGE = 5'd21, BR  = 5'd22, BOF = 5'd23;
    localparam logic [4:0] ILL = 5'd12;

    alu_seq #(.WIDTH(8), .OPW(5)) dut (
        .Clk(Clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .DatA(DatA), .DatB(DatB), .out_valid(out_valid), .Rslt(Rslt),
        .branch(branch), .flags(flags), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one op for one cycle; returns at the negedge after the accept edge.
    task automatic do_op(input logic [4:0] o, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1; op = o; DatA = a; DatB = b;
        @(posedge Clk);
        @(negedge Clk);
        in_valid = 1'b0;
    endtask

    // Iterative op: operands are scrambled after accept; returns at the out_valid negedge.
    task automatic run_multi(input string tag, input logic [4:0] o, input logic [7:0] a,
                             input logic [7:0] b, input logic [15:0] exp);
        int busy_cyc;
        logic got;
        busy_cyc = 0;
        got = 1'b0;
        in_valid = 1'b1; op = o; DatA = a; DatB = b;
        @(posedge Clk);
        @(negedge Clk);
        in_valid = 1'b0; DatA = 8'h00; DatB = 8'h00;
        for (int i = 0; i < 20 && !got; i++) begin
            if (out_valid) got = 1'b1;
            else begin
                if (busy && !in_ready) busy_cyc++;
                @(negedge Clk);
            end
        end
        chk({tag, "_seen"}, got, 1);
        chk({tag, "_busy_cycles"}, busy_cyc, 8);
        chk({tag, "_rslt"}, Rslt, exp);
        chk({tag, "_ready"}, in_ready, 1);
    endtask

    initial begin
        int saw_ov;
        reset = 1'b1; in_valid = 1'b0; op = '0; DatA = '0; DatB = '0;
        repeat (2) @(negedge Clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_rslt", Rslt, 0);
        chk("rst_branch", branch, 0);
        chk("rst_flags", flags, 0);
        reset = 1'b0;
        @(negedge Clk);

        do_op(ADD, 8'hF0, 8'h20);
        chk("add_ovalid", out_valid, 1);
        chk("add_rslt", Rslt, 16'h0110);
        chk("add_flags", flags, 4'b0010);
        @(negedge Clk);
        chk("add_pulse", out_valid, 0);

        do_op(CMP, 8'h05, 8'h05);
        chk("cmp55_rslt", Rslt, 0);
        chk("cmp55_flags", flags, 4'b0110);
        do_op(BEQ, 8'h00, 8'h00);
        chk("beq_ovalid", out_valid, 1);
        chk("beq", branch, 1);
        do_op(BNE, 8'h00, 8'h00);
        chk("bne", branch, 0);
        do_op(BLE, 8'h00, 8'h00);
        chk("ble_eq", branch, 1);
        do_op(BGT, 8'h00, 8'h00);
        chk("bgt_eq", branch, 0);

        do_op(CMP, 8'h03, 8'h07);
        chk("cmp37_flags", flags, 4'b1000);
        do_op(BLT, 8'h00, 8'h00);
        chk("blt", branch, 1);
        do_op(BGE, 8'h00, 8'h00);
        chk("bge", branch, 0);

        do_op(SUB, 8'h80, 8'h01);
        chk("sub_rslt", Rslt, 16'h007F);
        chk("sub_flags", flags, 4'b0011);
        do_op(BOF, 8'h00, 8'h00);
        chk("bof", branch, 1);

        run_multi("mul_ffff", MUL, 8'hFF, 8'hFF, 16'hFE01);
        chk("mul_out_valid", out_valid, 1);
        chk("mul_branch", branch, 0);
        chk("mul_flags", flags, 4'b0011);
        do_op(ADD, 8'h01, 8'h01);
        chk("add_after_mul_ovalid", out_valid, 1);
        chk("add_after_mul", Rslt, 16'h0002);
        chk("add_after_mul_flags", flags, 4'b0000);

        do_op(SUB, 8'h80, 8'h01);
        chk("pre_abort_flags", flags, 4'b0011);
        in_valid = 1'b1; op = MUL; DatA = 8'h03; DatB = 8'h04;
        @(posedge Clk);
        @(negedge Clk);
        in_valid = 1'b0;
        repeat (3) @(negedge Clk);
        chk("abort_busy", busy, 1);
        reset = 1'b1;
        @(negedge Clk);
        chk("abort_ready", in_ready, 1);
        chk("abort_ovalid", out_valid, 0);
        chk("abort_flags", flags, 0);
        reset = 1'b0;
        saw_ov = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (out_valid) saw_ov++;
        end
        chk("abort_no_ovalid", saw_ov, 0);
        run_multi("mul_3x4", MUL, 8'h03, 8'h04, 16'h000C);

        do_op(SHL, 8'h81, 8'h09);
        chk("shl9", Rslt, 0);
        do_op(SHL, 8'h81, 8'h01);
        chk("shl1", Rslt, 16'h0002);
        do_op(SHL, 8'h81, 8'h08);
        chk("shl8", Rslt, 0);
        do_op(SHR, 8'h80, 8'h07);
        chk("shr7", Rslt, 16'h0001);
        do_op(MOV, 8'h11, 8'h5A);
        chk("mov", Rslt, 16'h005A);

        do_op(ADD, 8'hFF, 8'h01);
        chk("add_wrap_rslt", Rslt, 16'h0100);
        chk("add_wrap_flags", flags, 4'b0110);
        do_op(BR, 8'h00, 8'h00);
        chk("b_always", branch, 1);
        do_op(ILL, 8'hFF, 8'hFF);
        chk("ill_ovalid", out_valid, 1);
        chk("ill_rslt", Rslt, 0);
        chk("ill_branch", branch, 0);
        chk("ill_flags", flags, 4'b0110);

`ifdef ALU_DIV_EN
        run_multi("div_100_7", DIV, 8'd100, 8'd7, 16'h020E);
        run_multi("div_9_0", DIV, 8'd9, 8'd0, 16'h09FF);
        chk("div0_flags", flags, 4'b0111);
`else
        do_op(MOV, 8'h00, 8'h33);
        do_op(DIV, 8'd100, 8'd7);
        chk("div_ill_ovalid", out_valid, 1);
        chk("div_ill_rslt", Rslt, 0);
        chk("div_ill_flags", flags, 4'b0110);
        chk("div_ill_ready", in_ready, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
